// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared definitions for the UART serial path.
//   tx_state_e   frame sequencing states, shared with the receiver
//   PARITY_*     parity mode encodings for the PARITY parameter
//   parity_bit() turns the XOR of a data word into the transmitted parity bit
package uart_tx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_e;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_ODD  = 1;
  localparam int PARITY_EVEN = 2;

  // Even parity repeats the XOR of the word; odd parity inverts it so the
  // total count of ones, parity bit included, comes out odd.
  function automatic logic parity_bit(input logic data_xor, input int mode);
    return (mode == PARITY_ODD) ? ~data_xor : data_xor;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: bit-period timer for the UART transmit and receive paths.
// Counts 0..CLKS_PER_BIT-1 and wraps, so every bit period is exactly
// CLKS_PER_BIT cycles with no accumulated drift.
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset
//   clear    in   hold the counter at 0 (the next period starts from scratch)
//   bit_end  out  high in the last cycle of each bit period
module uart_baud_gen
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic bit_end
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n || clear) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign bit_end = (cnt == LAST);

endmodule

// File: rtl/uart_tx.sv
// uart_tx: asynchronous serial transmitter. Takes one word over a valid/ready
// handshake and sends it LSB-first as start, data, optional parity and stop bits.
//   clk      in   clock, rising edge
//   rst_n    in   synchronous active-low reset; aborts any frame in flight
//   s_data   in   word to transmit (DATA_BITS wide)
//   s_valid  in   s_data is valid
//   s_ready  out  a word can be accepted (registered)
//   tx       out  serial line, idle high (registered)
//   busy     out  frame in progress (registered)
//
// state     | meaning
// ST_IDLE   | line high, ready for a word
// ST_START  | start bit (low) for one bit period
// ST_DATA   | data bits, LSB first, one bit period each
// ST_PARITY | parity bit, only when PARITY != PARITY_NONE
// ST_STOP   | line high for STOP_BITS bit periods
module uart_tx
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 868,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DATA_BITS-1:0] s_data,
  input  logic                 s_valid,
  output logic                 s_ready,
  output logic                 tx,
  output logic                 busy
);

  if (CLKS_PER_BIT < 2) begin : g_bad_clks_per_bit
    $error("uart_tx: CLKS_PER_BIT must be >= 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
    $error("uart_tx: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
    $error("uart_tx: STOP_BITS must be 1 or 2");
  end

  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

  tx_state_e            state, state_nx;
  logic [DATA_BITS-1:0] shreg, shreg_nx;
  logic [BCW-1:0]       bit_cnt, bit_cnt_nx;
  logic                 par_q, par_nx;
  logic                 tx_nx, ready_nx, busy_nx;
  logic                 bit_end;

  // The timer is parked at zero while idle so the start bit gets a full period.
  uart_baud_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (state == ST_IDLE),
    .bit_end(bit_end)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      par_q   <= 1'b0;
      tx      <= 1'b1;
      s_ready <= 1'b1;
      busy    <= 1'b0;
    end else begin
      state   <= state_nx;
      shreg   <= shreg_nx;
      bit_cnt <= bit_cnt_nx;
      par_q   <= par_nx;
      tx      <= tx_nx;
      s_ready <= ready_nx;
      busy    <= busy_nx;
    end
  end

  // Outputs are registered, so each branch sets the line level for the
  // period that begins at the upcoming edge.
  always_comb begin
    state_nx   = state;
    shreg_nx   = shreg;
    bit_cnt_nx = bit_cnt;
    par_nx     = par_q;
    tx_nx      = tx;
    ready_nx   = s_ready;
    busy_nx    = busy;
    case (state)
      ST_IDLE: begin
        tx_nx    = 1'b1;
        ready_nx = 1'b1;
        busy_nx  = 1'b0;
        if (s_valid && s_ready) begin
          state_nx   = ST_START;
          shreg_nx   = s_data;
          par_nx     = parity_bit(^s_data, PARITY);
          bit_cnt_nx = '0;
          tx_nx      = 1'b0;
          ready_nx   = 1'b0;
          busy_nx    = 1'b1;
        end
      end
      ST_START: begin
        if (bit_end) begin
          state_nx = ST_DATA;
          tx_nx    = shreg[0];
          shreg_nx = shreg >> 1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_nx = '0;
            if (PARITY != PARITY_NONE) begin
              state_nx = ST_PARITY;
              tx_nx    = par_q;
            end else begin
              state_nx = ST_STOP;
              tx_nx    = 1'b1;
            end
          end else begin
            bit_cnt_nx = bit_cnt + 1'b1;
            tx_nx      = shreg[0];
            shreg_nx   = shreg >> 1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_nx = ST_STOP;
          tx_nx    = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (bit_cnt == LAST_STOP) begin
            state_nx   = ST_IDLE;
            bit_cnt_nx = '0;
            ready_nx   = 1'b1;
            busy_nx    = 1'b0;
          end else begin
            bit_cnt_nx = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_nx = ST_IDLE;
        tx_nx    = 1'b1;
        ready_nx = 1'b1;
        busy_nx  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Testbench for uart_tx: five configurations side by side (8N1, 8E1, 8O1,
// 8N2, 5N1) at 4 clocks per bit. Stimulus queues the hand-written frame
// waveform it expects; one monitor per instance detects start bits and
// checks every cycle of the frame against the queued entry.
module tb_uart_tx;
  import uart_tx_pkg::*;

  localparam int CPB = 4;

  typedef struct packed {
    logic [15:0] bits;     // bit i = line level in bit slot i
    logic [4:0]  len;      // number of bit slots in the frame
    logic        gap_chk;  // check idle cycles before this frame's start
    logic [7:0]  gap;
  } frame_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [8:0] s_data_v [5];
  logic       s_valid_v [5];
  logic       s_ready_v [5];
  logic       tx_v [5];
  logic       busy_v [5];

  int checks = 0;
  int failures = 0;

  frame_t exp_q [5][$];

  always #5 clk = ~clk;

  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_v[0][7:0]), .s_valid(s_valid_v[0]),
    .s_ready(s_ready_v[0]), .tx(tx_v[0]), .busy(busy_v[0]));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_EVEN), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_v[1][7:0]), .s_valid(s_valid_v[1]),
    .s_ready(s_ready_v[1]), .tx(tx_v[1]), .busy(busy_v[1]));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_ODD), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_v[2][7:0]), .s_valid(s_valid_v[2]),
    .s_ready(s_ready_v[2]), .tx(tx_v[2]), .busy(busy_v[2]));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(PARITY_NONE), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_v[3][7:0]), .s_valid(s_valid_v[3]),
    .s_ready(s_ready_v[3]), .tx(tx_v[3]), .busy(busy_v[3]));
  uart_tx #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(PARITY_NONE), .STOP_BITS(1)) u_5n1 (
    .clk(clk), .rst_n(rst_n), .s_data(s_data_v[4][4:0]), .s_valid(s_valid_v[4]),
    .s_ready(s_ready_v[4]), .tx(tx_v[4]), .busy(busy_v[4]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Frame from a time-ordered string of '0'/'1' bit slots.
  function automatic frame_t mk(input string s, input int gap);
    frame_t f;
    f = '0;
    for (int i = 0; i < s.len(); i++) f.bits[i] = (s[i] == 8'h31);
    f.len = 5'(s.len());
    f.gap_chk = (gap >= 0);
    f.gap = 8'(gap);
    return f;
  endfunction

  task automatic wait_rdy(input int k, input logic lvl);
    int n;
    n = 0;
    while (s_ready_v[k] !== lvl && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk($sformatf("ready_wait_u%0d", k), 32'(s_ready_v[k]), 32'(lvl));
  endtask

  task automatic send(input int k, input logic [8:0] d, input string s, input int gap);
    wait_rdy(k, 1'b1);
    exp_q[k].push_back(mk(s, gap));
    s_data_v[k]  = d;
    s_valid_v[k] = 1'b1;
    @(posedge clk); #1;
    s_valid_v[k] = 1'b0;
    chk($sformatf("busy_after_accept_u%0d", k), 32'(busy_v[k]), 32'd1);
  endtask

  task automatic mon(input int k);
    int idle;
    int total;
    int bad;
    int rlow;
    int bhigh;
    logic ab;
    frame_t e;
    idle = -1;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        idle = -1;
        continue;
      end
      if (tx_v[k] === 1'b1) begin
        if (idle >= 0) idle++;
        continue;
      end
      checks++;
      if (exp_q[k].size() == 0) begin
        failures++;
        $display("FAIL unexpected_frame_u%0d: start bit seen, got 0 queued frames expected 1", k);
        while (busy_v[k] === 1'b1 && rst_n) @(negedge clk);
        idle = -1;
        continue;
      end
      e = exp_q[k].pop_front();
      if (e.gap_chk) chk($sformatf("idle_gap_u%0d", k), 32'(idle), 32'(e.gap));
      total = int'(e.len) * CPB;
      bad = -1;
      rlow = 0;
      bhigh = 0;
      ab = 1'b0;
      for (int c = 0; c < total; c++) begin
        if (c > 0) @(negedge clk);
        if (!rst_n) begin
          ab = 1'b1;
          break;
        end
        if (tx_v[k] !== e.bits[c / CPB] && bad < 0) bad = c;
        if (s_ready_v[k] === 1'b0) rlow++;
        if (busy_v[k] === 1'b1) bhigh++;
      end
      chk($sformatf("frame_wave_first_bad_cycle_u%0d", k), 32'(bad), 32'hFFFF_FFFF);
      if (!ab) begin
        chk($sformatf("ready_low_cycles_u%0d", k), 32'(rlow), 32'(total));
        chk($sformatf("busy_high_cycles_u%0d", k), 32'(bhigh), 32'(total));
      end
      idle = ab ? -1 : 0;
    end
  endtask

  initial mon(0);
  initial mon(1);
  initial mon(2);
  initial mon(3);
  initial mon(4);

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, got running expected finished");
    $fatal(1);
  end

  initial begin
    for (int k = 0; k < 5; k++) begin
      s_data_v[k]  = '0;
      s_valid_v[k] = 1'b0;
    end
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("reset_tx_u%0d", k), 32'(tx_v[k]), 32'd1);
      chk($sformatf("reset_ready_u%0d", k), 32'(s_ready_v[k]), 32'd1);
      chk($sformatf("reset_busy_u%0d", k), 32'(busy_v[k]), 32'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 8N1 frames, then a mid-frame pulse with different data that must be ignored
    send(0, 9'h0A5, "0101001011", -1);
    send(0, 9'h03C, "0001111001", -1);
    repeat (10) @(posedge clk);
    #1;
    s_data_v[0]  = 9'h081;
    s_valid_v[0] = 1'b1;
    @(posedge clk); #1;
    s_valid_v[0] = 1'b0;
    s_data_v[0]  = 9'h000;

    // parity even/odd and 5-bit words
    send(1, 9'h0A5, "01010010101", -1);
    send(2, 9'h0A5, "01010010111", -1);
    send(4, 9'h01F, "0111111", -1);
    send(1, 9'h001, "01000000011", -1);
    send(4, 9'h00A, "0010101", -1);

    // two stop bits, s_valid held high across back-to-back frames
    wait_rdy(3, 1'b1);
    exp_q[3].push_back(mk("00000000011", -1));
    exp_q[3].push_back(mk("01111111111", 1));
    s_data_v[3]  = 9'h000;
    s_valid_v[3] = 1'b1;
    wait_rdy(3, 1'b0);
    s_data_v[3] = 9'h0FF;
    wait_rdy(3, 1'b1);
    wait_rdy(3, 1'b0);
    s_valid_v[3] = 1'b0;

    // reset during data bit 3 (cycles 16..19 of the frame)
    for (int k = 0; k < 5; k++) wait_rdy(k, 1'b1);
    send(0, 9'h0A5, "0101001011", -1);
    repeat (17) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("abort_tx", 32'(tx_v[0]), 32'd1);
    chk("abort_busy", 32'(busy_v[0]), 32'd0);
    chk("abort_ready", 32'(s_ready_v[0]), 32'd1);
    rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 9'h05A, "0010110101", -1);

    for (int k = 0; k < 5; k++) wait_rdy(k, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 5; k++)
      chk($sformatf("frames_outstanding_u%0d", k), 32'(exp_q[k].size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
